parallax_starfield: RTL
=======================

PARALLAX_STARFIELD -- requirements
Module: parallax_starfield

Interface
REQ-001 The block SHALL have parameter LFSR_W, default 19, giving the LFSR width per layer.
REQ-002 The block SHALL have parameter TAPS, default 19'b1110010000000000000, giving the Galois feedback taps.
REQ-003 The block SHALL have parameter LAYERS, default 3, giving the star layer count (1..4); layer 0 is nearest.
REQ-004 The block SHALL have parameters FIELD_W = 640 and FIELD_H = 480, giving the star field size in pixels.
REQ-005 The block SHALL have parameter DENSITY, default 9: a star shows when the top DENSITY bits of a layer LFSR are all ones.
REQ-006 The block SHALL have parameter SPEEDS, default {8'd4,8'd2,8'd1}, a packed 8-bit left-scroll speed per layer in pixels/frame (layer 0 is the LSB byte).
REQ-007 The block SHALL have port clk, input, 1 bit: the pixel clock, with one clock and all state on its rising edge.
REQ-008 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-009 The block SHALL have port hpos, input, 10 bits: the current pixel column from the external sync generator.
REQ-010 The block SHALL have port vpos, input, 10 bits: the current pixel row.
REQ-011 The block SHALL have port display_on, input, 1 bit: the active-video flag.
REQ-012 The block SHALL have port scroll_en, input, 1 bit: when high, seeds advance at frame end.
REQ-013 The block SHALL have port rgb, output, 3 bits: registered pixel colour.
REQ-014 The block SHALL have port star_hit, output, 1 bit: registered flag, some layer shows a star.
REQ-015 The block SHALL have port layer_id, output, 2 bits: registered index of the winning layer.

Function
REQ-016 in_field SHALL be (hpos < FIELD_W) & (vpos < FIELD_H).
REQ-017 Each layer i SHALL hold a pixel LFSR lfsr_i and a frame seed seed_i.
REQ-018 An LFSR step SHALL be x -> {1'b0, x[W-1:1]} ^ (x[0] ? TAPS : 0).
REQ-019 In RUN state, every lfsr_i SHALL step once per clock while in_field; outside in_field it SHALL hold.
REQ-020 The FSM SHALL have states RUN, ADV and LOAD.
REQ-021 In RUN, on the cycle with vpos == FIELD_H and hpos == 0, the FSM SHALL go to ADV if scroll_en is high, else to LOAD.
REQ-022 ADV SHALL use step counter cnt, 0..MAX_SPEED-1, where MAX_SPEED = max(SPEEDS); seed_i SHALL step once on each ADV cycle with cnt < SPEED_i.
REQ-023 ADV SHALL last exactly MAX_SPEED cycles, then go to LOAD; if MAX_SPEED == 0, ADV SHALL be skipped.
REQ-024 LOAD SHALL last one cycle: lfsr_i <= seed_i for all i, cnt <= 0, then RUN.
REQ-025 scroll_en SHALL be sampled only on the RUN->ADV/LOAD decision; changes during ADV SHALL be ignored.
REQ-026 A layer i star SHALL be hit_i = in_field & display_on & (&lfsr_i[W-1:W-DENSITY]).
REQ-027 Priority SHALL go to the lowest index: layer_id is the lowest i with hit_i, and 0 when none.
REQ-028 Colour SHALL be 3'b111 for layer 0, lfsr_i[2:0] for layer i > 0, and 3'b000 when no hit.
REQ-029 rgb, star_hit and layer_id SHALL be registered, with a latency of exactly 1 clock from hpos/vpos/display_on.
REQ-030 Elaboration SHALL assert that MAX_SPEED + 1 is less than the vertical-blank clock count.
REQ-031 Elaboration SHALL assert that DENSITY <= LFSR_W.

Reset
REQ-032 While reset_n is low, state SHALL be RUN, cnt 0, and rgb, star_hit and layer_id 0.
REQ-033 While reset_n is low, seed_i and lfsr_i SHALL be SEED_i = {W{1'b1}} ^ i, which is non-zero and distinct per layer.
REQ-034 A reset asserted mid-ADV or mid-LOAD SHALL abandon the operation, with no partial seed retained.
REQ-035 Reset SHALL be asynchronous assert with synchronous-safe deassert, relying on the external synchroniser.

Structure
REQ-036 Package starfield_pkg SHALL hold the default TAPS, the LFSR step function and the FSM state enum.
REQ-037 Sub-module lfsr_galois (parameters W and TAPS; inputs step and load; load value) SHALL be instantiated twice per layer, once for pixel and once for seed.

Verification
REQ-038 Scenario: release reset with hpos = 0, vpos = 0, display_on = 1 -> next cycle star_hit = 1, layer_id = 0, rgb = 3'b111.
REQ-039 Scenario: one in_field clock after reset -> lfsr_0 = 19'h4DFFF; with hpos = 700 -> rgb = 0 and lfsr_0 holds.
REQ-040 Scenario: SPEEDS = {4,2,1}, scroll_en = 1, two full frames -> layer-0 output at frame2 (0,0) equals its frame1 (1,0), and layer 2 at frame2 (0,0) equals its frame1 (4,0).
REQ-041 Scenario: scroll_en = 0, two frames -> every pixel of frame2 is identical to frame1.
REQ-042 Scenario: reset_n pulsed low on cycle 2 of ADV -> state RUN and all seeds equal SEED_i; the following frame equals the first post-reset frame.
REQ-043 Scenario: force layers 0 and 1 to hit on the same pixel -> layer_id = 0 and rgb = 3'b111.

Source files
------------

// File: rtl/starfield_pkg.sv
// Shared pieces of the parallax starfield: default Galois taps, the LFSR step
// function and the frame-sequencing FSM states.
package starfield_pkg;

  localparam int LFSR_MAX_W = 32;

  localparam logic [18:0] DEFAULT_TAPS = 19'b1110010000000000000;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_ADV  = 2'd1,
    ST_LOAD = 2'd2
  } star_state_e;

  // Callers zero-extend narrower registers; the shift brings in a zero, so the
  // result stays within the caller's width as long as the taps do.
  function automatic logic [LFSR_MAX_W-1:0] lfsr_step(
    input logic [LFSR_MAX_W-1:0] x,
    input logic [LFSR_MAX_W-1:0] taps
  );
    return {1'b0, x[LFSR_MAX_W-1:1]} ^ (x[0] ? taps : '0);
  endfunction

endpackage

// File: rtl/lfsr_galois.sv
// Galois LFSR register with load (priority) and step enables; the new value
// appears one clock after the request; it never stalls.
module lfsr_galois
  import starfield_pkg::*;
#(
  parameter int             W       = 19,
  parameter logic [W-1:0]   TAPS    = W'(DEFAULT_TAPS),
  parameter logic [W-1:0]   RST_VAL = '1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         step_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic [W-1:0] q_o
);

  if (W < 3 || W > LFSR_MAX_W) begin : g_bad_width
    $error("lfsr_galois: W must be 3..%0d", LFSR_MAX_W);
  end

  logic [W-1:0]          lfsr_q;
  logic [W-1:0]          lfsr_d;
  logic [LFSR_MAX_W-1:0] next_full;
  logic                  unused_next_bits;

  assign next_full        = lfsr_step(LFSR_MAX_W'(lfsr_q), LFSR_MAX_W'(TAPS));
  assign unused_next_bits = ^next_full;

  always_comb begin
    lfsr_d = lfsr_q;
    if (load_i) begin
      lfsr_d = load_val_i;
    end else if (step_i) begin
      lfsr_d = next_full[W-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lfsr_q <= RST_VAL;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign q_o = lfsr_q;

endmodule

// File: rtl/parallax_starfield.sv
// Multi-layer scrolling starfield: per-layer pixel/seed LFSRs, seeds advanced in
// vertical blank; outputs registered with 1 clock latency, no backpressure.
module parallax_starfield
  import starfield_pkg::*;
#(
  parameter int                  LFSR_W  = 19,
  parameter logic [LFSR_W-1:0]   TAPS    = LFSR_W'(DEFAULT_TAPS),
  parameter int                  LAYERS  = 3,
  parameter int                  FIELD_W = 640,
  parameter int                  FIELD_H = 480,
  parameter int                  DENSITY = 9,
  parameter logic [8*LAYERS-1:0] SPEEDS  = {8'd4, 8'd2, 8'd1}
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [9:0] hpos,
  input  logic [9:0] vpos,
  input  logic       display_on,
  input  logic       scroll_en,
  output logic [2:0] rgb,
  output logic       star_hit,
  output logic [1:0] layer_id
);

  function automatic int max_speed();
    int m;
    m = 0;
    for (int i = 0; i < LAYERS; i++) begin
      if (32'(SPEEDS[8*i +: 8]) > m) m = 32'(SPEEDS[8*i +: 8]);
    end
    return m;
  endfunction

  localparam int         MAX_SPEED = max_speed();
  localparam logic [7:0] LAST_CNT  = (MAX_SPEED == 0) ? 8'd0 : 8'(MAX_SPEED - 1);

  if (LAYERS < 1 || LAYERS > 4) begin : g_bad_layers
    $error("parallax_starfield: LAYERS must be 1..4");
  end
  if (DENSITY < 1 || DENSITY > LFSR_W) begin : g_bad_density
    $error("parallax_starfield: DENSITY must be 1..LFSR_W");
  end
  // Vertical blank lasts at least one whole line, itself at least FIELD_W clocks.
  if (MAX_SPEED + 1 >= FIELD_W) begin : g_bad_blank
    $error("parallax_starfield: MAX_SPEED+1 must fit inside vertical blank");
  end

  star_state_e      state_q;
  logic [7:0]       cnt_q;
  logic             in_field;
  logic             frame_end;
  logic             pix_step;
  logic             pix_load;
  logic [LAYERS-1:0] hit;

  logic [LFSR_W-1:0] pix_q  [LAYERS];
  logic [LFSR_W-1:0] seed_q [LAYERS];

  logic [2:0] rgb_d,      rgb_q;
  logic       star_hit_d, star_hit_q;
  logic [1:0] layer_id_d, layer_id_q;

  assign in_field  = ({1'b0, hpos} < 11'(FIELD_W)) & ({1'b0, vpos} < 11'(FIELD_H));
  assign frame_end = (vpos == 10'(FIELD_H)) && (hpos == 10'd0);
  assign pix_step  = (state_q == ST_RUN) && in_field;
  assign pix_load  = (state_q == ST_LOAD);

  // scroll_en matters only on the frame-end decision; ADV runs to completion.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (frame_end) begin
            state_q <= (scroll_en && (MAX_SPEED != 0)) ? ST_ADV : ST_LOAD;
          end
        end
        ST_ADV: begin
          if (cnt_q == LAST_CNT) begin
            state_q <= ST_LOAD;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        ST_LOAD: begin
          state_q <= ST_RUN;
          cnt_q   <= '0;
        end
        default: begin
          state_q <= ST_RUN;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  for (genvar gi = 0; gi < LAYERS; gi++) begin : g_layer
    localparam logic [LFSR_W-1:0] SEED = {LFSR_W{1'b1}} ^ LFSR_W'(gi);

    logic seed_step;
    logic unused_pix_bits;

    assign seed_step = (state_q == ST_ADV) && (cnt_q < SPEEDS[8*gi +: 8]);

    lfsr_galois #(
      .W       (LFSR_W),
      .TAPS    (TAPS),
      .RST_VAL (SEED)
    ) u_seed (
      .clk        (clk),
      .reset_n    (reset_n),
      .step_i     (seed_step),
      .load_i     (1'b0),
      .load_val_i ('0),
      .q_o        (seed_q[gi])
    );

    lfsr_galois #(
      .W       (LFSR_W),
      .TAPS    (TAPS),
      .RST_VAL (SEED)
    ) u_pix (
      .clk        (clk),
      .reset_n    (reset_n),
      .step_i     (pix_step),
      .load_i     (pix_load),
      .load_val_i (seed_q[gi]),
      .q_o        (pix_q[gi])
    );

    assign hit[gi]         = in_field & display_on & (&pix_q[gi][LFSR_W-1 -: DENSITY]);
    assign unused_pix_bits = ^pix_q[gi];
  end

  // Walk from the farthest layer inward so the nearest hit wins.
  always_comb begin
    star_hit_d = |hit;
    layer_id_d = 2'd0;
    rgb_d      = 3'b000;
    for (int i = LAYERS - 1; i >= 0; i--) begin
      if (hit[i]) begin
        layer_id_d = 2'(i);
        rgb_d      = (i == 0) ? 3'b111 : pix_q[i][2:0];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rgb_q      <= 3'b000;
      star_hit_q <= 1'b0;
      layer_id_q <= 2'd0;
    end else begin
      rgb_q      <= rgb_d;
      star_hit_q <= star_hit_d;
      layer_id_q <= layer_id_d;
    end
  end

  assign rgb      = rgb_q;
  assign star_hit = star_hit_q;
  assign layer_id = layer_id_q;

endmodule
